vtc_prog: RTL and testbench

VTC_PROG -- requirements
Module: vtc_prog

---
 rtl/vtc_prog.sv | 186 ++++++++++++++++++
 tb/tb_vtc_prog.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtc_prog.sv
// Programmable video timing controller with double-buffered timing set.
// New timing is accepted into a pending set and applied only at frame wrap.
module vtc_prog #(
  parameter int COUNTER_WIDTH = 12,
  parameter int DEF_H_ACTIVE = 640,
  parameter int DEF_H_FP = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP = 48,
  parameter int DEF_V_ACTIVE = 480,
  parameter int DEF_V_FP = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP = 33,
  parameter bit DEF_HS_POL = 1'b1,
  parameter bit DEF_VS_POL = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_en,
  input  logic                     i_cfg_load,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_h_active,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_h_fp,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_h_sync,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_h_bp,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_v_active,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_v_fp,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_v_sync,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_v_bp,
  input  logic                     i_cfg_hs_pol,
  input  logic                     i_cfg_vs_pol,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_active,
  output logic                     o_sof,
  output logic                     o_eol,
  output logic [COUNTER_WIDTH-1:0] o_counterX,
  output logic [COUNTER_WIDTH-1:0] o_counterY,
  output logic                     o_cfg_pending,
  output logic                     o_cfg_rej
);

  localparam int CW = COUNTER_WIDTH;
  localparam int TW = CW + 2;
  localparam logic [TW-1:0] LIM = TW'(1) << CW;

  typedef struct packed {
    logic [CW-1:0] ha;
    logic [CW-1:0] hf;
    logic [CW-1:0] hs;
    logic [CW-1:0] hb;
    logic [CW-1:0] va;
    logic [CW-1:0] vf;
    logic [CW-1:0] vs;
    logic [CW-1:0] vb;
    logic          hp;
    logic          vp;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    ha: CW'(DEF_H_ACTIVE),
    hf: CW'(DEF_H_FP),
    hs: CW'(DEF_H_SYNC),
    hb: CW'(DEF_H_BP),
    va: CW'(DEF_V_ACTIVE),
    vf: CW'(DEF_V_FP),
    vs: CW'(DEF_V_SYNC),
    vb: CW'(DEF_V_BP),
    hp: DEF_HS_POL,
    vp: DEF_VS_POL
  };

  function automatic logic [TW-1:0] ext(input logic [CW-1:0] v);
    return {2'b00, v};
  endfunction

  cfg_t          act;
  cfg_t          pnd;
  cfg_t          ld_cfg;
  logic          pend;
  logic [CW-1:0] cnt_x;
  logic [CW-1:0] cnt_y;

  logic [TW-1:0] htot;
  logic [TW-1:0] vtot;
  logic [TW-1:0] ld_htot;
  logic [TW-1:0] ld_vtot;
  logic [TW-1:0] hs_lo;
  logic [TW-1:0] hs_hi;
  logic [TW-1:0] vs_lo;
  logic [TW-1:0] vs_hi;
  logic          x_last;
  logic          y_last;
  logic          wrap;
  logic          ld_bad;
  logic          ld_ok;
  logic          in_hs;
  logic          in_vs;
  logic          act_d;
  logic          sof_d;
  logic          eol_d;

  always_comb begin
    ld_cfg = '{
      ha: i_cfg_h_active,
      hf: i_cfg_h_fp,
      hs: i_cfg_h_sync,
      hb: i_cfg_h_bp,
      va: i_cfg_v_active,
      vf: i_cfg_v_fp,
      vs: i_cfg_v_sync,
      vb: i_cfg_v_bp,
      hp: i_cfg_hs_pol,
      vp: i_cfg_vs_pol
    };
    htot = ext(act.ha) + ext(act.hf)
         + ext(act.hs) + ext(act.hb);
    vtot = ext(act.va) + ext(act.vf)
         + ext(act.vs) + ext(act.vb);
    ld_htot = ext(ld_cfg.ha) + ext(ld_cfg.hf)
            + ext(ld_cfg.hs) + ext(ld_cfg.hb);
    ld_vtot = ext(ld_cfg.va) + ext(ld_cfg.vf)
            + ext(ld_cfg.vs) + ext(ld_cfg.vb);
    ld_bad = (ld_cfg.ha == '0) || (ld_cfg.va == '0)
          || (ld_cfg.hs == '0) || (ld_cfg.vs == '0)
          || (ld_htot > LIM) || (ld_vtot > LIM);
    ld_ok  = i_cfg_load && !ld_bad;
    x_last = ext(cnt_x) == (htot - TW'(1));
    y_last = ext(cnt_y) == (vtot - TW'(1));
    wrap   = i_en && x_last && y_last;
    hs_lo  = ext(act.ha) + ext(act.hf);
    hs_hi  = hs_lo + ext(act.hs);
    vs_lo  = ext(act.va) + ext(act.vf);
    vs_hi  = vs_lo + ext(act.vs);
    in_hs  = (ext(cnt_x) >= hs_lo) && (ext(cnt_x) < hs_hi);
    in_vs  = (ext(cnt_y) >= vs_lo) && (ext(cnt_y) < vs_hi);
    act_d  = (cnt_x < act.ha) && (cnt_y < act.va);
    sof_d  = (cnt_x == '0) && (cnt_y == '0);
    eol_d  = (cnt_x == act.ha - CW'(1)) && (cnt_y < act.va);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      act           <= DEF_CFG;
      pnd           <= DEF_CFG;
      pend          <= 1'b0;
      cnt_x         <= '0;
      cnt_y         <= '0;
      o_hsync       <= ~DEF_HS_POL;
      o_vsync       <= ~DEF_VS_POL;
      o_active      <= 1'b0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      o_counterX    <= '0;
      o_counterY    <= '0;
      o_cfg_pending <= 1'b0;
      o_cfg_rej     <= 1'b0;
    end else begin
      o_cfg_rej <= i_cfg_load && ld_bad;
      o_sof     <= i_en && sof_d;
      o_eol     <= i_en && eol_d;
      // wrap consumes the old pending set before a coincident load refills it
      if (wrap && pend) begin
        act  <= pnd;
        pend <= 1'b0;
      end
      if (ld_ok) begin
        pnd  <= ld_cfg;
        pend <= 1'b1;
      end
      o_cfg_pending <= ld_ok || (pend && !wrap);
      if (i_en) begin
        o_hsync    <= act.hp ? in_hs : ~in_hs;
        o_vsync    <= act.vp ? in_vs : ~in_vs;
        o_active   <= act_d;
        o_counterX <= cnt_x;
        o_counterY <= cnt_y;
        if (x_last) begin
          cnt_x <= '0;
          cnt_y <= y_last ? '0 : cnt_y + CW'(1);
        end else begin
          cnt_x <= cnt_x + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vtc_prog.sv
// Bench for vtc_prog: cycle model feeding an expected-output queue,
// plus directed frame-length and sync-position measurements.
module tb_vtc_prog;

  localparam int CW = 8;
  localparam int LIM = 1 << CW;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
  } mcfg_t;

  typedef struct packed {
    logic hs, vs, act, sof, eol;
    logic [CW-1:0] cx, cy;
    logic pend, rej;
  } out_t;

  logic i_clk, i_rstn, i_en, i_cfg_load;
  logic [CW-1:0] h_a, h_f, h_s, h_b;
  logic [CW-1:0] v_a, v_f, v_s, v_b;
  logic hs_pol, vs_pol;
  logic o_hsync, o_vsync, o_active, o_sof, o_eol;
  logic [CW-1:0] o_counterX, o_counterY;
  logic o_cfg_pending, o_cfg_rej;

  vtc_prog #(
    .COUNTER_WIDTH(CW),
    .DEF_H_ACTIVE(20), .DEF_H_FP(4),
    .DEF_H_SYNC(6), .DEF_H_BP(10),
    .DEF_V_ACTIVE(12), .DEF_V_FP(2),
    .DEF_V_SYNC(3), .DEF_V_BP(5),
    .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_en(i_en), .i_cfg_load(i_cfg_load),
    .i_cfg_h_active(h_a), .i_cfg_h_fp(h_f),
    .i_cfg_h_sync(h_s), .i_cfg_h_bp(h_b),
    .i_cfg_v_active(v_a), .i_cfg_v_fp(v_f),
    .i_cfg_v_sync(v_s), .i_cfg_v_bp(v_b),
    .i_cfg_hs_pol(hs_pol), .i_cfg_vs_pol(vs_pol),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_active(o_active), .o_sof(o_sof),
    .o_eol(o_eol),
    .o_counterX(o_counterX), .o_counterY(o_counterY),
    .o_cfg_pending(o_cfg_pending),
    .o_cfg_rej(o_cfg_rej)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  mcfg_t defc = '{20, 4, 6, 10, 12, 2, 3, 5, 1'b1, 1'b1};
  mcfg_t nocfg = '{0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
  mcfg_t ma, mp;
  bit mpend;
  int mx, my;
  out_t mo, last;
  out_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  string tag = "init";

  function automatic int mht();
    return ma.ha + ma.hf + ma.hs + ma.hb;
  endfunction

  function automatic int mvt();
    return ma.va + ma.vf + ma.vs + ma.vb;
  endfunction

  task automatic chk(input string t, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", t, obs, expv);
    end
  endtask

  task automatic step(input bit en, input bit ld,
                      input mcfg_t c, input bit rst);
    out_t e, obs;
    int ht, vt, cht, cvt;
    bit bad, ok, w, inh, inv;
    i_rstn = !rst;
    i_en = en;
    i_cfg_load = ld;
    h_a = CW'(c.ha); h_f = CW'(c.hf);
    h_s = CW'(c.hs); h_b = CW'(c.hb);
    v_a = CW'(c.va); v_f = CW'(c.vf);
    v_s = CW'(c.vs); v_b = CW'(c.vb);
    hs_pol = c.hp; vs_pol = c.vp;
    if (rst) begin
      ma = defc; mp = defc; mpend = 0;
      mx = 0; my = 0;
      mo = '0;
      mo.hs = !defc.hp;
      mo.vs = !defc.vp;
    end else begin
      ht = mht();
      vt = mvt();
      cht = c.ha + c.hf + c.hs + c.hb;
      cvt = c.va + c.vf + c.vs + c.vb;
      bad = ld && (c.ha == 0 || c.va == 0 || c.hs == 0
            || c.vs == 0 || cht > LIM || cvt > LIM);
      ok = ld && !bad;
      mo.rej = bad;
      if (en) begin
        inh = mx >= ma.ha + ma.hf
           && mx < ma.ha + ma.hf + ma.hs;
        inv = my >= ma.va + ma.vf
           && my < ma.va + ma.vf + ma.vs;
        mo.hs = ma.hp ? inh : !inh;
        mo.vs = ma.vp ? inv : !inv;
        mo.act = mx < ma.ha && my < ma.va;
        mo.sof = mx == 0 && my == 0;
        mo.eol = mx == ma.ha - 1 && my < ma.va;
        mo.cx = CW'(mx);
        mo.cy = CW'(my);
      end else begin
        mo.sof = 0;
        mo.eol = 0;
      end
      w = en && mx == ht - 1 && my == vt - 1;
      if (w && mpend) begin
        ma = mp;
        mpend = 0;
      end
      if (ok) begin
        mp = c;
        mpend = 1;
      end
      mo.pend = mpend;
      if (en) begin
        if (mx == ht - 1) begin
          mx = 0;
          my = (my == vt - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
    end
    exp_q.push_back(mo);
    @(posedge i_clk);
    #1;
    obs.hs = o_hsync; obs.vs = o_vsync;
    obs.act = o_active; obs.sof = o_sof;
    obs.eol = o_eol;
    obs.cx = o_counterX; obs.cy = o_counterY;
    obs.pend = o_cfg_pending; obs.rej = o_cfg_rej;
    e = exp_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    last = obs;
  endtask

  task automatic wait_sof(output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, nocfg, 1'b0);
      n++;
    end while (!last.sof && n < 5000);
    chk({tag, "_sof_seen"}, int'(last.sof), 1);
  endtask

  task automatic run_until_hs(input bit pol, output int x);
    int k = 0;
    while (last.hs !== pol && k < 2000) begin
      step(1'b1, 1'b0, nocfg, 1'b0);
      k++;
    end
    x = int'(last.cx);
  endtask

  mcfg_t ca, cb, cc, ce, bad1, bad2;
  int n, k, x;

  initial begin
    ca = '{30, 3, 5, 8, 10, 2, 2, 4, 1'b1, 1'b1};
    cb = ca;
    cb.hp = 0;
    cb.vp = 0;
    cc = '{16, 2, 4, 6, 8, 1, 2, 3, 1'b1, 1'b1};
    ce = '{200, 20, 20, 16, 4, 1, 1, 1, 1'b1, 1'b1};
    bad1 = ca;
    bad1.hs = 0;
    bad2 = '{200, 20, 20, 20, 4, 1, 1, 1, 1'b1, 1'b1};

    tag = "reset";
    repeat (3) step(1'b1, 1'b0, nocfg, 1'b1);
    chk("reset_hsync", int'(last.hs), 0);

    tag = "first";
    wait_sof(n);
    chk("first_sof_latency", n, 1);
    chk("first_active", int'(last.act), 1);

    tag = "default";
    wait_sof(n);
    chk("default_period", n, 880);
    run_until_hs(1'b1, x);
    chk("default_hs_start", x, 24);

    tag = "reject";
    step(1'b1, 1'b1, bad1, 1'b0);
    step(1'b1, 1'b0, nocfg, 1'b0);
    step(1'b1, 1'b1, bad2, 1'b0);
    chk("reject_total_rej", int'(last.rej), 1);
    chk("reject_pending", int'(last.pend), 0);

    tag = "load_a";
    step(1'b1, 1'b1, ca, 1'b0);
    chk("load_a_pending", int'(last.pend), 1);
    wait_sof(n);
    chk("load_a_old_frame", int'(last.pend), 0);
    wait_sof(n);
    chk("load_a_period", n, 828);
    run_until_hs(1'b1, x);
    chk("load_a_hs_start", x, 33);

    tag = "pol";
    step(1'b1, 1'b1, cb, 1'b0);
    k = 0;
    while (!(mx == mht() - 1 && my == mvt() - 1)
           && k < 2000) begin
      step(1'b1, 1'b0, nocfg, 1'b0);
      k++;
    end
    step(1'b1, 1'b1, cc, 1'b0);
    chk("pol_wrap_pending", int'(last.pend), 1);
    wait_sof(n);
    chk("pol_inverted_hs", int'(last.hs), 1);
    wait_sof(n);
    chk("pol_frame_period", n, 828);
    wait_sof(n);
    chk("pol_second_cfg_period", n, 392);

    tag = "boundary";
    step(1'b1, 1'b1, ce, 1'b0);
    chk("boundary_256_rej", int'(last.rej), 0);
    step(1'b1, 1'b1, defc, 1'b0);
    wait_sof(n);
    wait_sof(n);
    chk("boundary_overwrite_period", n, 880);

    tag = "en_gate";
    k = 0;
    while (last.cx != 10 && k < 2000) begin
      step(1'b1, 1'b0, nocfg, 1'b0);
      k++;
    end
    repeat (50) step(1'b0, 1'b0, nocfg, 1'b0);
    chk("en_gate_frozen_x", int'(last.cx), 10);
    wait_sof(n);
    chk("en_gate_period", k + 50 + n, 930);

    tag = "reset_mid";
    step(1'b1, 1'b1, ca, 1'b0);
    k = 0;
    while (last.cy != 15 && k < 2000) begin
      step(1'b1, 1'b0, nocfg, 1'b0);
      k++;
    end
    step(1'b1, 1'b0, nocfg, 1'b1);
    chk("reset_mid_pending", int'(last.pend), 0);
    wait_sof(n);
    chk("reset_mid_restart", n, 1);
    wait_sof(n);
    chk("reset_mid_period", n, 880);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
